// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a multi-cycle
// FP occupancy tracker that freezes EX while an FP mul/div is in flight.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] id_ctrl,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        ex_flush,
  output logic [14:0] ex_ctrl,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        stall,
  output logic        fp_busy
);

  typedef enum logic {IDLE, FP_HOLD} state_t;

  localparam logic [3:0] FP_OP_MUL = 4'd2;
  localparam logic [3:0] FP_OP_DIV = 4'd3;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;

  logic [14:0] r_ex_ctrl;
  logic [31:0] r_ex_rs_data;
  logic [31:0] r_ex_rt_data;
  logic [31:0] r_ex_imm;
  logic [4:0]  r_ex_rs;
  logic [4:0]  r_ex_rt;
  logic [4:0]  r_ex_rd;
  logic        r_ex_valid;

  logic        w_load_use;
  logic        w_capture;
  logic        w_bubble;
  logic        w_idle;

  assign w_idle = (r_state == IDLE);

  assign w_load_use = r_ex_valid & r_ex_ctrl[3] & (r_ex_rt != 5'd0) & id_valid &
                      ((r_ex_rt == id_rs) | (r_ex_rt == id_rt));

  assign w_capture = ~ex_flush & w_idle & ~w_load_use & id_valid;
  // In IDLE anything that is not a capture becomes a bubble; FP_HOLD holds.
  assign w_bubble  = ex_flush | (w_idle & ~w_capture);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (ex_flush) begin
      w_state_next = IDLE;
      w_cnt_next   = 3'd0;
    end else if (r_state == FP_HOLD) begin
      if (r_cnt <= 3'd1) begin
        w_state_next = IDLE;
        w_cnt_next   = 3'd0;
      end else begin
        w_cnt_next = r_cnt - 3'd1;
      end
    end else if (w_capture && id_ctrl[10]) begin
      case (id_ctrl[14:11])
        FP_OP_MUL: begin
          w_state_next = FP_HOLD;
          w_cnt_next   = 3'd2;
        end
        FP_OP_DIV: begin
          w_state_next = FP_HOLD;
          w_cnt_next   = 3'd5;
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_ctrl    <= '0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_ex_valid   <= 1'b0;
    end else if (w_capture) begin
      r_ex_ctrl    <= id_ctrl;
      r_ex_rs_data <= id_rs_data;
      r_ex_rt_data <= id_rt_data;
      r_ex_imm     <= id_imm;
      r_ex_rs      <= id_rs;
      r_ex_rt      <= id_rt;
      r_ex_rd      <= id_rd;
      r_ex_valid   <= 1'b1;
    end else if (w_bubble) begin
      r_ex_ctrl    <= '0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_ex_valid   <= 1'b0;
    end
  end

  assign fp_busy    = (r_state == FP_HOLD);
  // A taken branch/jump overrides any hold so the front end can redirect.
  assign stall      = ~ex_flush & (fp_busy | (w_load_use & w_idle));

  assign ex_ctrl    = r_ex_ctrl;
  assign ex_rs_data = r_ex_rs_data;
  assign ex_rt_data = r_ex_rt_data;
  assign ex_imm     = r_ex_imm;
  assign ex_rs      = r_ex_rs;
  assign ex_rt      = r_ex_rt;
  assign ex_rd      = r_ex_rd;
  assign ex_valid   = r_ex_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: capture latency, load-use stall,
// FP mul/div occupancy, flush override and asynchronous reset.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [14:0] id_ctrl;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_flush;
  logic [14:0] ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid, stall, fp_busy;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [14:0] C_ADDI = 15'h0022;  // ALUsrc | Regwrite
  localparam logic [14:0] C_ADD  = 15'h0021;  // RegDst | Regwrite
  localparam logic [14:0] C_LW   = 15'h012A;  // ALUsrc | Memread | Regwrite | MemtoReg
  localparam logic [14:0] C_FADD = 15'h0400;  // FP, op 0
  localparam logic [14:0] C_FMUL = 15'h1400;  // FP, op 2
  localparam logic [14:0] C_FDIV = 15'h1C00;  // FP, op 3

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_flush(ex_flush),
    .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .stall(stall), .fp_busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else begin
      n_pass++;
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [14:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] imm);
    id_valid   = v;
    id_ctrl    = c;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_rs_data = rsd;
    id_rt_data = 32'hA5A5_0000 | {27'd0, rt};
    id_imm     = imm;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ex_flush = 1'b0;
    drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5);
    #11;
    // Reset held across an edge with a valid ID instruction present.
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_ctrl", {17'd0, ex_ctrl}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fp_busy", {31'd0, fp_busy}, 32'd0);
    rst_n = 1'b1;

    // addi, then idle
    check("addi_stall_pre", {31'd0, stall}, 32'd0);
    tick();
    check("addi_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("addi_ex_rd", {27'd0, ex_rd}, 32'd3);
    check("addi_ex_imm", ex_imm, 32'd5);
    check("addi_ex_ctrl", {17'd0, ex_ctrl}, 32'h22);
    drive(1'b0, 15'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    check("addi_stall_post", {31'd0, stall}, 32'd0);
    tick();
    check("idle_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("idle_bubble_rd", {27'd0, ex_rd}, 32'd0);

    // lw rt=4 then add using rs=4
    drive(1'b1, C_LW, 5'd1, 5'd4, 5'd0, 32'd0, 32'd8);
    tick();
    check("lw_ex_rt", {27'd0, ex_rt}, 32'd4);
    drive(1'b1, C_ADD, 5'd4, 5'd2, 5'd6, 32'd100, 32'd0);
    check("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_ctrl", {17'd0, ex_ctrl}, 32'd0);
    check("lu_stall_clear", {31'd0, stall}, 32'd0);
    tick();
    check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_add_rd", {27'd0, ex_rd}, 32'd6);
    check("lu_add_rsdata", ex_rs_data, 32'd100);

    // lw with rt=4 matched via id_rt instead of id_rs
    drive(1'b1, C_LW, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0);
    tick();
    drive(1'b1, C_ADD, 5'd9, 5'd4, 5'd12, 32'd0, 32'd0);
    check("lu_rt_stall", {31'd0, stall}, 32'd1);
    tick();
    check("lu_rt_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    check("lu_rt_add_rd", {27'd0, ex_rd}, 32'd12);

    // lw rt=0 never stalls
    drive(1'b1, C_LW, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    tick();
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0);
    check("r0_stall", {31'd0, stall}, 32'd0);
    tick();
    check("r0_valid", {31'd0, ex_valid}, 32'd1);
    check("r0_rd", {27'd0, ex_rd}, 32'd7);

    // FP add: single cycle
    drive(1'b1, C_FADD, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0);
    tick();
    check("fadd_busy", {31'd0, fp_busy}, 32'd0);
    check("fadd_rd", {27'd0, ex_rd}, 32'd8);

    // FP div: 5 busy cycles, next capture on 6th edge
    drive(1'b1, C_FDIV, 5'd1, 5'd2, 5'd9, 32'd0, 32'd0);
    tick();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd10, 32'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("div_busy_%0d", k), {31'd0, fp_busy}, 32'd1);
      check($sformatf("div_stall_%0d", k), {31'd0, stall}, 32'd1);
      check($sformatf("div_hold_rd_%0d", k), {27'd0, ex_rd}, 32'd9);
      tick();
    end
    check("div_done_busy", {31'd0, fp_busy}, 32'd0);
    check("div_done_stall", {31'd0, stall}, 32'd0);
    check("div_done_ctrl", {17'd0, ex_ctrl}, {17'd0, C_FDIV});
    tick();
    check("div_next_rd", {27'd0, ex_rd}, 32'd10);
    check("div_next_valid", {31'd0, ex_valid}, 32'd1);

    // FP mul: 2 busy cycles
    drive(1'b1, C_FMUL, 5'd1, 5'd2, 5'd13, 32'd0, 32'd0);
    tick();
    drive(1'b0, 15'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    check("mul_busy_0", {31'd0, fp_busy}, 32'd1);
    tick();
    check("mul_busy_1", {31'd0, fp_busy}, 32'd1);
    tick();
    check("mul_busy_end", {31'd0, fp_busy}, 32'd0);

    // flush during mul hold with a pending load-use
    drive(1'b1, C_FMUL | 15'h0008, 5'd1, 5'd4, 5'd14, 32'd0, 32'd0);
    tick();
    drive(1'b1, C_ADD, 5'd4, 5'd2, 5'd15, 32'd0, 32'd0);
    check("fl_stall_pre", {31'd0, stall}, 32'd1);
    ex_flush = 1'b1;
    #1;
    check("fl_stall_comb", {31'd0, stall}, 32'd0);
    tick();
    ex_flush = 1'b0;
    #1;
    check("fl_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_bubble_ctrl", {17'd0, ex_ctrl}, 32'd0);
    check("fl_busy", {31'd0, fp_busy}, 32'd0);
    check("fl_stall_post", {31'd0, stall}, 32'd0);
    tick();
    check("fl_resume_rd", {27'd0, ex_rd}, 32'd15);

    // async reset mid FP_HOLD
    drive(1'b1, C_FDIV, 5'd1, 5'd2, 5'd9, 32'd0, 32'd0);
    tick();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd11, 32'd0, 32'd0);
    tick();
    check("ar_busy_pre", {31'd0, fp_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, ex_valid}, 32'd0);
    check("ar_rd", {27'd0, ex_rd}, 32'd0);
    check("ar_busy", {31'd0, fp_busy}, 32'd0);
    check("ar_stall", {31'd0, stall}, 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("ar_stall_rel", {31'd0, stall}, 32'd0);
    tick();
    check("ar_resume_valid", {31'd0, ex_valid}, 32'd1);
    check("ar_resume_rd", {27'd0, ex_rd}, 32'd11);
    check("ar_resume_busy", {31'd0, fp_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port id_ctrl  in  15  decoded control from the ID stage: [0]RegDst [1]ALUsrc [2]Memwrite [3]Memread [4]Branch [5]Regwrite [7:6]ALUop [8]MemtoReg [9]jump [10]FP_instruction [14:11]FP_ALUop.
REQ-004 SHALL have port id_valid  in  1  ID stage holds a real instruction.
REQ-005 SHALL have ports id_rs_data, id_rt_data, id_imm  in  32 each  operand values and sign-extended immediate.
REQ-006 SHALL have ports id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-007 SHALL have port ex_flush  in  1  branch/jump resolved taken; kill instruction entering EX.
REQ-008 SHALL have ports ex_ctrl (15), ex_rs_data, ex_rt_data, ex_imm (32), ex_rs, ex_rt, ex_rd (5), ex_valid (1)  out  registered EX-stage copies.
REQ-009 SHALL have port stall  out  1  combinational; holds PC and IF/ID register when 1.
REQ-010 SHALL have port fp_busy  out  1  registered; multi-cycle FP op occupying EX.

Function
REQ-011 Bubble SHALL mean ex_valid=0, ex_ctrl=0; data/specifier fields don't-care (implementation drives 0).
REQ-012 Load-use hazard SHALL be: ex_valid & ex_ctrl[3] & (ex_rt!=0) & id_valid & (ex_rt==id_rs | ex_rt==id_rt).
REQ-013 FSM SHALL have states IDLE and FP_HOLD with a 3-bit down-counter cnt.
REQ-014 Capture of an FP instruction (id_ctrl[10]=1) in IDLE SHALL load cnt by FP_ALUop: 0/1 (add/sub) -> stay IDLE; 2 (mul) -> cnt=2, go FP_HOLD; 3 (div) -> cnt=5, go FP_HOLD; other codes -> stay IDLE.
REQ-015 In FP_HOLD cnt SHALL decrement each cycle; at cnt==1 transition to IDLE next edge (total EX occupancy: mul 3 cycles, div 6 cycles).
REQ-016 fp_busy SHALL equal (state==FP_HOLD).
REQ-017 stall SHALL equal fp_busy | (load-use hazard & state==IDLE), and SHALL be 0 while ex_flush=1.
REQ-018 Register update priority per edge SHALL be: ex_flush -> bubble, state=IDLE, cnt=0; else FP_HOLD -> hold all ex_* outputs; else load-use hazard -> bubble; else id_valid=0 -> bubble; else capture all id_* into ex_*.
REQ-019 Latency id_* -> ex_* SHALL be exactly one cycle when no stall/flush.
REQ-020 A stalled ID instruction SHALL be captured on the first edge after stall deasserts (no loss, no duplication).
REQ-021 ex_flush coincident with the last FP_HOLD cycle or a load-use hazard SHALL still yield exactly one bubble and IDLE.
REQ-022 ex_rt==0 SHALL never raise a load-use hazard.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force all ex_* outputs to 0, state=IDLE, cnt=0, fp_busy=0.
REQ-024 stall SHALL be 0 during reset; first capture SHALL occur on the first rising edge after rst_n rises.
REQ-025 Reset asserted mid FP_HOLD SHALL abort the op with no residual stall after release.

Verification
REQ-026 addi (id_ctrl bit5,1 set, id_rd=3, id_imm=5) then idle -> next edge ex_valid=1, ex_rd=3, ex_imm=5, stall=0 throughout.
REQ-027 lw ex_rt=4 in EX, ID add with id_rs=4 -> stall=1 one cycle, bubble in EX, add captured on following edge.
REQ-028 lw ex_rt=0, ID id_rs=0 -> stall=0, no bubble.
REQ-029 FP div (FP_ALUop=3) captured -> fp_busy=1 for 5 cycles, stall=1 same cycles, ex_* held; next ID instruction captured on 6th edge after div capture.
REQ-030 ex_flush=1 during FP mul hold with pending load-use -> next edge bubble, fp_busy=0, stall=0.
REQ-031 rst_n pulsed low mid-clock during FP_HOLD -> outputs 0 immediately without clock edge; after release normal capture resumes.
